mcdf_arbiter: RTL and testbench
===============================

// Module: mcdf_arbiter
// PURPOSE
//  Downstream of the per-channel slave nodes. Selects one channel whose FIFO holds a complete packet and drains
//  exactly one packet of words from it via the channel fetch strobe. Presents the words to the formatter on a
//  registered valid/ready output carrying channel id, length and start/end markers. Sits between the slave nodes
//  and the formatter.
// PARAMETERS
//  CH_NUM      3    number of slave channels; id width = 2
//  DATA_W      32   word width
//  FIFO_DEPTH  32   slave FIFO depth; freeslot width = 6
// PORTS
//  clk_i         in   1           clock
//  rst_i         in   1           synchronous reset, active-high
//  ch_data_i     in   CH_NUM*32   slave FIFO head words; ch c at [c*32+:32]
//  ch_valid_i    in   CH_NUM      slave FIFO non-empty
//  ch_freeslot_i in   CH_NUM*6    slave FIFO free slots
//  ch_fetch_o    out  CH_NUM      pop strobe to slave FIFO; one-hot or zero
//  ch_en_i       in   CH_NUM      register: channel enable
//  ch_prio_i     in   CH_NUM*2    register: priority, 0 = highest
//  ch_len_i      in   CH_NUM*2    register: packet length code 0/1/2/3 -> 4/8/16/32 words
//  out_valid_o   out  1           output word valid
//  out_ready_i   in   1           formatter accepts word
//  out_data_o    out  32          output word
//  out_id_o      out  2           source channel
//  out_len_o     out  6           packet length in words (4..32; 32 encoded as 6'd32)
//  out_sop_o     out  1           first word of packet
//  out_eop_o     out  1           last word of packet
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, word counter 0, rr pointer 0. Reset mid-burst aborts; no fetch on the reset cycle.
//  - Eligible(c) = ch_en_i[c] && (FIFO_DEPTH - ch_freeslot_i[c]) >= len(c). Occupancy is 6-bit unsigned; freeslot > DEPTH is never eligible.
//  - FSM IDLE: if any eligible, pick the lowest prio value; ties resolved per CONFIGURATION. Latch gnt id, len and
//    words_left = len; go BURST. No fetch in IDLE. Arbitration costs 1 cycle; there is always >=1 IDLE cycle between packets.
//  - FSM BURST: fetch_ok = ch_valid_i[gnt] && (!out_valid_o || out_ready_i). ch_fetch_o[gnt] = fetch_ok (combinational).
//    On fetch: the output register loads ch_data_i[gnt], id, len, sop = (words_left == len), eop = (words_left == 1);
//    words_left decrements. On the fetch with words_left == 1 -> IDLE.
//  - Output register: out_valid_o set on load, cleared on out_ready_i with no new load; out_* held stable while valid && !ready.
//  - Throughput: 1 word/cycle while the formatter is ready; latency fetch -> out_valid_o = 1 cycle.
//  - ch_valid_i[gnt] low mid-burst: stall, counter holds, no fetch; resume when high.
//  - ch_en_i / ch_prio_i / ch_len_i sampled only in IDLE; changes during BURST take effect at the next arbitration.
//  - Granted channel disabled mid-burst: packet still completes (no truncation).
//  - Last word accepted with words_left == 1: state is IDLE on the next cycle; output stays valid until accepted.
// CONFIGURATION
//  - ARB_ROUND_ROBIN_EN defined: ties among equal priority are resolved round-robin. Search starts at rr_ptr;
//    rr_ptr <= gnt+1 (mod CH_NUM) on each grant.
//  - ARB_ROUND_ROBIN_EN undefined: ties are resolved by fixed priority, lowest channel index wins. No rr_ptr register.
// STRUCTURE
//  - mcdf_pkg: CH_NUM, DATA_W, FIFO_DEPTH constants; arb_state_e {IDLE, BURST}; function len_decode(2b) -> 6b.
//  - Sub-module mcdf_arb_pick: combinational. Inputs: eligible vector, priorities, rr_ptr. Outputs: gnt index, any_elig.
//    Holds the ARB_ROUND_ROBIN_EN switch.
//  - Top: FSM, words_left counter, output register, fetch decode.
// TESTING
//  1 Ch0 len code 0, freeslot 28, valid, ready = 1 -> 4 fetches on consecutive cycles starting the cycle after grant;
//    out sop on word 0, eop on word 3, id = 0, len = 4.
//  2 Ch1 freeslot 25 (7 words), len code 1 (8) -> never granted; freeslot drops to 24 -> grant the next cycle, 8 words out.
//  3 All eligible, prio {2,1,1} for ch{0,1,2}, len 4 -> grant order 1,2,1,2 with the macro; 1,1,1 without.
//    Ch0 served only when ch1/ch2 are not eligible.
//  4 out_ready_i low 3 cycles mid-packet -> out_* stable, ch_fetch_o = 0 during the stall, no lost or duplicated word (scoreboard vs FIFO model).
//  5 ch_len_i changed 0->3 during a 4-word burst -> current packet is 4 words; the next packet is 32 words.
//  6 rst_i asserted on the 2nd word of a burst -> next cycle: out_valid_o = 0, ch_fetch_o = 0, state IDLE;
//    re-arbitration after rst_i deasserts.

Source files
------------

// File: rtl/mcdf_pkg.sv
// Shared constants, FSM state type and length-code decode for the MCDF arbiter slice.
package mcdf_pkg;

  localparam int unsigned CH_NUM     = 3;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FIFO_DEPTH = 32;
  localparam int unsigned ID_W       = 2;
  localparam int unsigned PRIO_W     = 2;
  localparam int unsigned LEN_W      = 2;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Packet length code 0/1/2/3 -> 4/8/16/32 words.
  function automatic logic [CNT_W-1:0] len_decode(input logic [LEN_W-1:0] code);
    logic [CNT_W-1:0] len;
    case (code)
      2'd0:    len = 6'd4;
      2'd1:    len = 6'd8;
      2'd2:    len = 6'd16;
      default: len = 6'd32;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mcdf_arb_pick.sv
// Combinational channel picker: lowest priority value wins; ties broken round-robin
// when ARB_ROUND_ROBIN_EN is defined, otherwise lowest channel index wins.
module mcdf_arb_pick
  import mcdf_pkg::*;
(
  input  logic [CH_NUM-1:0]        elig_i,
  input  logic [CH_NUM*PRIO_W-1:0] prio_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]          rr_ptr_i,
`endif
  output logic [ID_W-1:0]          gnt_o,
  output logic                     any_elig_o
);

  logic [PRIO_W-1:0] best_prio;
  logic              found;
  int unsigned       idx;

  always_comb begin
    best_prio  = '1;
    found      = 1'b0;
    idx        = 0;
    gnt_o      = '0;
    any_elig_o = |elig_i;

    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (elig_i[c] && (prio_i[c*PRIO_W +: PRIO_W] < best_prio)) begin
        best_prio = prio_i[c*PRIO_W +: PRIO_W];
      end
    end

    // Second pass walks the channels in tie-break order and takes the first at best_prio.
    for (int unsigned k = 0; k < CH_NUM; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = (32'(rr_ptr_i) + k) % CH_NUM;
`else
      idx = k;
`endif
      if (!found && elig_i[idx] && (prio_i[idx*PRIO_W +: PRIO_W] == best_prio)) begin
        gnt_o = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants one channel holding a full packet and drains it to a registered
// valid/ready output. Optional round-robin tie-break via ARB_ROUND_ROBIN_EN.
module mcdf_arbiter
  import mcdf_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [CH_NUM*DATA_W-1:0]   ch_data_i,
  input  logic [CH_NUM-1:0]          ch_valid_i,
  input  logic [CH_NUM*CNT_W-1:0]    ch_freeslot_i,
  output logic [CH_NUM-1:0]          ch_fetch_o,
  input  logic [CH_NUM-1:0]          ch_en_i,
  input  logic [CH_NUM*PRIO_W-1:0]   ch_prio_i,
  input  logic [CH_NUM*LEN_W-1:0]    ch_len_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [ID_W-1:0]            out_id_o,
  output logic [CNT_W-1:0]           out_len_o,
  output logic                       out_sop_o,
  output logic                       out_eop_o
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  words_left_q, words_left_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [CNT_W-1:0]  out_len_q, out_len_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  logic [CH_NUM-1:0] elig;
  logic [CNT_W-1:0]  fs;
  logic [ID_W-1:0]   pick_gnt;
  logic              any_elig;
  logic              fetch_ok;

  // Freeslot above depth would underflow the occupancy, so it is excluded outright.
  always_comb begin
    elig = '0;
    fs   = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      fs = ch_freeslot_i[c*CNT_W +: CNT_W];
      elig[c] = ch_en_i[c] && (fs <= CNT_W'(FIFO_DEPTH)) &&
                ((CNT_W'(FIFO_DEPTH) - fs) >= len_decode(ch_len_i[c*LEN_W +: LEN_W]));
    end
  end

  mcdf_arb_pick u_pick (
    .elig_i     (elig),
    .prio_i     (ch_prio_i),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr_i   (rr_ptr_q),
`endif
    .gnt_o      (pick_gnt),
    .any_elig_o (any_elig)
  );

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    len_d        = len_q;
    words_left_d = words_left_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    out_len_d    = out_len_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    fetch_ok     = 1'b0;
    ch_fetch_o   = '0;

    case (state_q)
      IDLE: begin
        if (any_elig) begin
          gnt_d        = pick_gnt;
          len_d        = len_decode(ch_len_i[pick_gnt*LEN_W +: LEN_W]);
          words_left_d = len_d;
          state_d      = BURST;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d     = (pick_gnt == ID_W'(CH_NUM-1)) ? '0 : pick_gnt + ID_W'(1);
`endif
        end
      end
      BURST: begin
        // Reset gates the strobe so an aborted burst never pops the slave FIFO.
        fetch_ok = ch_valid_i[gnt_q] && (!out_valid_q || out_ready_i) && !rst_i;
      end
      default: state_d = IDLE;
    endcase

    if (fetch_ok) begin
      ch_fetch_o[gnt_q] = 1'b1;
      out_valid_d       = 1'b1;
      out_data_d        = ch_data_i[gnt_q*DATA_W +: DATA_W];
      out_id_d          = gnt_q;
      out_len_d         = len_q;
      out_sop_d         = (words_left_q == len_q);
      out_eop_d         = (words_left_q == CNT_W'(1));
      words_left_d      = words_left_q - CNT_W'(1);
      if (words_left_q == CNT_W'(1)) begin
        state_d = IDLE;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      len_q        <= '0;
      words_left_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      out_len_q    <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      len_q        <= len_d;
      words_left_q <= words_left_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      out_len_q    <= out_len_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign out_len_o   = out_len_q;
  assign out_sop_o   = out_sop_q;
  assign out_eop_o   = out_eop_q;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Randomized scoreboard bench for mcdf_arbiter with slave FIFO models and a packet-level reference.
module tb_mcdf_arbiter;

  localparam int NCH = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [95:0]   ch_data_i;
  logic [2:0]    ch_valid_i;
  logic [17:0]   ch_freeslot_i;
  logic [2:0]    ch_fetch_o;
  logic [2:0]    ch_en_i;
  logic [5:0]    ch_prio_i;
  logic [5:0]    ch_len_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_data_o;
  logic [1:0]    out_id_o;
  logic [5:0]    out_len_o;
  logic          out_sop_o;
  logic          out_eop_o;

  mcdf_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ch_data_i     (ch_data_i),
    .ch_valid_i    (ch_valid_i),
    .ch_freeslot_i (ch_freeslot_i),
    .ch_fetch_o    (ch_fetch_o),
    .ch_en_i       (ch_en_i),
    .ch_prio_i     (ch_prio_i),
    .ch_len_i      (ch_len_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_id_o      (out_id_o),
    .out_len_o     (out_len_o),
    .out_sop_o     (out_sop_o),
    .out_eop_o     (out_eop_o)
  );

  always #5 clk = ~clk;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic [5:0]  len;
    logic        sop;
    logic        eop;
  } exp_t;

  wq_t  fifo_q [NCH];
  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // reference-model state
  bit m_busy    = 1'b0;
  int m_gnt     = 0;
  int m_left    = 0;
  int m_len     = 0;
  int m_rr      = 0;
  bit after_rst = 1'b0;

  // stimulus knobs
  int       push_pct, ready_pct, stall_pct, lenchg_pct, ovr_pct;
  bit [2:0] push_mask;
  bit       stall_mask [NCH];
  bit       ovr        [NCH];
  int       ovr_val    [NCH];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic apply_ports();
    for (int c = 0; c < NCH; c++) begin
      ch_data_i[c*32 +: 32]    = (fifo_q[c].size() > 0) ? fifo_q[c][0] : 32'h0;
      ch_valid_i[c]            = (fifo_q[c].size() > 0) && !stall_mask[c];
      ch_freeslot_i[c*6 +: 6]  = ovr[c] ? 6'(ovr_val[c]) : 6'(32 - fifo_q[c].size());
    end
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (push_mask[c] && ($urandom_range(99) < push_pct) && (fifo_q[c].size() < 32))
        fifo_q[c].push_back($urandom);
      stall_mask[c] = ($urandom_range(99) < stall_pct);
      ovr[c]        = ($urandom_range(99) < ovr_pct);
      ovr_val[c]    = 33 + $urandom_range(30);
    end
    out_ready_i = ($urandom_range(99) < ready_pct);
    if ($urandom_range(99) < lenchg_pct) ch_len_i = 6'($urandom);
    apply_ports();
  endtask

  task automatic set_phase(input logic [2:0] en, input logic [5:0] prio, input logic [5:0] len,
                           input bit [2:0] pmask, input int push, input int rdy,
                           input int stall, input int lenchg, input int ovrp);
    ch_en_i    = en;
    ch_prio_i  = prio;
    ch_len_i   = len;
    push_mask  = pmask;
    push_pct   = push;
    ready_pct  = rdy;
    stall_pct  = stall;
    lenchg_pct = lenchg;
    ovr_pct    = ovrp;
  endtask

  // Packet-level arbitration from the channel rules: full-packet eligibility, min prio, tie-break.
  task automatic arbitrate();
    bit elig [NCH];
    int best, found, c, L, fs;
    best  = 4;
    found = -1;
    for (int i = 0; i < NCH; i++) begin
      fs      = int'(ch_freeslot_i[i*6 +: 6]);
      L       = 4 << ch_len_i[i*2 +: 2];
      elig[i] = ch_en_i[i] && (fs <= 32) && ((32 - fs) >= L);
      if (elig[i] && (int'(ch_prio_i[i*2 +: 2]) < best)) best = int'(ch_prio_i[i*2 +: 2]);
    end
    for (int k = 0; k < NCH; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      c = (m_rr + k) % NCH;
`else
      c = k;
`endif
      if (found < 0 && elig[c] && (int'(ch_prio_i[c*2 +: 2]) == best)) found = c;
    end
    if (found >= 0) begin
      L = 4 << ch_len_i[found*2 +: 2];
      for (int k = 0; k < L; k++) begin
        exp_t e;
        e.data = (k < fifo_q[found].size()) ? fifo_q[found][k] : 32'hDEAD_BEEF;
        e.id   = 2'(found);
        e.len  = 6'(L);
        e.sop  = (k == 0);
        e.eop  = (k == L - 1);
        sb_q.push_back(e);
      end
      m_busy = 1'b1;
      m_gnt  = found;
      m_left = L;
      m_len  = L;
      m_rr   = (found + 1) % NCH;
    end
  endtask

  // Reference model: predicts the fetch strobe, tracks FIFO pops and issues packet expectations.
  always @(negedge clk) begin : model
    logic [2:0] exp_f;
    if (rst_i) begin
      chk("fetch_during_reset", ch_fetch_o, 3'b000);
      m_busy    = 1'b0;
      m_rr      = 0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("valid_after_reset", out_valid_o, 1'b0);
        after_rst = 1'b0;
      end
      exp_f = 3'b000;
      if (m_busy && ch_valid_i[m_gnt] && (!out_valid_o || out_ready_i)) exp_f[m_gnt] = 1'b1;
      chk("fetch", ch_fetch_o, exp_f);
      for (int c = 0; c < NCH; c++)
        if (ch_fetch_o[c] === 1'b1 && fifo_q[c].size() > 0) void'(fifo_q[c].pop_front());
      if (m_busy) begin
        if (ch_fetch_o[m_gnt] === 1'b1) begin
          m_left--;
          if (m_left == 0) m_busy = 1'b0;
        end
      end else begin
        arbitrate();
      end
    end
  end

  // Monitor: compares every accepted word and checks hold-stability under backpressure.
  logic [41:0] held;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_i) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid_o, 1'b1);
        chk("hold_fields", {out_data_o, out_id_o, out_len_o, out_sop_o, out_eop_o}, held);
      end
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %h id %0d with none expected", out_data_o, out_id_o);
        end else begin
          e = sb_q.pop_front();
          chk("out_word", {out_data_o, out_id_o, out_len_o, out_sop_o, out_eop_o},
              {e.data, e.id, e.len, e.sop, e.eop});
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      held       = {out_data_o, out_id_o, out_len_o, out_sop_o, out_eop_o};
    end
  end

  initial begin
    bit rst_done;
    rst_i       = 1'b1;
    out_ready_i = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      stall_mask[c] = 1'b0;
      ovr[c]        = 1'b0;
      ovr_val[c]    = 33;
    end
    set_phase(3'b000, 6'd0, 6'd0, 3'b000, 0, 100, 0, 0, 0);
    apply_ports();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid_o, out_data_o, out_id_o, out_len_o, out_sop_o, out_eop_o, ch_fetch_o},
        45'd0);
    rst_i = 1'b0;

    // ch0 only, 4-word packets, formatter always ready
    set_phase(3'b001, 6'b00_00_00, 6'b00_00_00, 3'b001, 70, 100, 0, 0, 0);
    repeat (60) drive_cycle();
    // ch1 only, 8-word packets, filling slowly across the threshold
    set_phase(3'b010, 6'b00_00_00, 6'b00_01_00, 3'b010, 30, 100, 0, 0, 0);
    repeat (100) drive_cycle();
    // all channels, ch0 lower priority than the ch1/ch2 tie
    set_phase(3'b111, 6'b01_01_10, 6'b00_00_00, 3'b111, 80, 100, 0, 0, 0);
    repeat (150) drive_cycle();
    // backpressure and slave-empty stalls
    set_phase(3'b111, 6'($urandom), 6'($urandom), 3'b111, 60, 55, 12, 0, 0);
    repeat (300) drive_cycle();
    // length code changing while bursts are in flight
    set_phase(3'b111, 6'b00_00_00, 6'b00_00_00, 3'b111, 70, 80, 0, 15, 0);
    repeat (300) drive_cycle();

    // synchronous reset on the second word of a burst
    set_phase(3'b001, 6'b00_00_00, 6'b00_00_01, 3'b001, 90, 100, 0, 0, 0);
    rst_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive_cycle();
      if (!rst_done && m_busy && (m_left == m_len - 1)) begin
        rst_i    = 1'b1;
        drive_cycle();
        rst_i    = 1'b0;
        rst_done = 1'b1;
      end
    end
    chk("midburst_reset_hit", rst_done, 1'b1);

    // fully random, including freeslot values above depth
    for (int p = 0; p < 4; p++) begin
      set_phase(3'($urandom), 6'($urandom), 6'($urandom), 3'b111,
                40 + $urandom_range(50), 40 + $urandom_range(60), $urandom_range(15),
                $urandom_range(10), 8);
      repeat (250) drive_cycle();
    end

    // drain with producers off and formatter ready
    set_phase(ch_en_i, ch_prio_i, ch_len_i, 3'b000, 0, 100, 0, 0, 0);
    repeat (800) drive_cycle();
    chk("drain_busy", m_busy, 1'b0);
    chk("drain_scoreboard", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
